// File: rtl/dvp_tx_pkg.sv
// dvp_tx_pkg
//   Shared definitions for the DVP pattern transmitter: the frame FSM state
//   type, the eight RGB565 colour-bar constants (left to right) and small
//   helpers used when sizing counters and picking bar colours.
//   Build option: DVP_TX_FRAME_TAG_EN (used by dvp_pattern_tx, not here).
package dvp_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        VSYNC,
        VBACK,
        ACTIVE,
        HBLANK,
        VFRONT
    } dvp_state_e;

    localparam logic [15:0] BAR_WHITE   = 16'hFFFF;
    localparam logic [15:0] BAR_YELLOW  = 16'hFFE0;
    localparam logic [15:0] BAR_CYAN    = 16'h07FF;
    localparam logic [15:0] BAR_GREEN   = 16'h07E0;
    localparam logic [15:0] BAR_MAGENTA = 16'hF81F;
    localparam logic [15:0] BAR_RED     = 16'hF800;
    localparam logic [15:0] BAR_BLUE    = 16'h001F;
    localparam logic [15:0] BAR_BLACK   = 16'h0000;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [15:0] bar_colour(input logic [2:0] idx);
        case (idx)
            3'd0:    return BAR_WHITE;
            3'd1:    return BAR_YELLOW;
            3'd2:    return BAR_CYAN;
            3'd3:    return BAR_GREEN;
            3'd4:    return BAR_MAGENTA;
            3'd5:    return BAR_RED;
            3'd6:    return BAR_BLUE;
            default: return BAR_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/dvp_pattern_gen.sv
// dvp_pattern_gen
//   Combinational RGB565 pixel generator.
//   Ports:
//     x           [15:0] in  : pixel column, from 0
//     y           [15:0] in  : line number, from 0
//     pattern_sel        in  : 0 = eight colour bars, 1 = ramp (x + y)
//     pixel       [15:0] out : RGB565 value for (x, y)
//   Bars are H_PIXEL/8 pixels wide; columns past the eighth bar are black.
module dvp_pattern_gen
    import dvp_tx_pkg::*;
#(
    parameter int unsigned H_PIXEL = 640
) (
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic        pattern_sel,
    output logic [15:0] pixel
);

    localparam int unsigned BAR_W   = H_PIXEL / 8;
    localparam int unsigned BAR_END = 8 * BAR_W;
    // Divisor kept non-zero so narrow lines (no full bars) still elaborate.
    localparam int unsigned BAR_DIV = (BAR_W == 0) ? 1 : BAR_W;

    logic [2:0]  bar_idx;
    logic [15:0] bar_pix;

    always_comb begin
        bar_idx = '0;
        bar_pix = BAR_BLACK;
        if (32'(x) < BAR_END) begin
            bar_idx = 3'(32'(x) / BAR_DIV);
            bar_pix = bar_colour(bar_idx);
        end
        pixel = pattern_sel ? (x + y) : bar_pix;
    end

endmodule

// File: rtl/dvp_pattern_tx.sv
// dvp_pattern_tx
//   DVP (camera-style) test-pattern transmitter. Emits frames of RGB565
//   pixels, high byte first, one byte per clock.
//   Ports:
//     sys_clk          in  : clock, one DVP byte per cycle
//     sys_rst_n        in  : synchronous active-low reset
//     tx_en            in  : run request, honoured only at frame boundaries
//     pattern_sel      in  : 0 = colour bars, 1 = ramp; latched at VSYNC entry
//     dvp_vsync        out : frame sync, active high
//     dvp_href         out : line valid, active high
//     dvp_data   [7:0] out : pixel byte, 0 whenever dvp_href is low
//     busy             out : high from leaving IDLE until returning to IDLE
//     frame_done       out : one-cycle pulse on the last V_FRONT clock
//   Build option: DVP_TX_FRAME_TAG_EN replaces pixel (0,0) of each frame
//   with a 16-bit frame counter that advances on every frame_done.
module dvp_pattern_tx
    import dvp_tx_pkg::*;
#(
    parameter int unsigned H_PIXEL = 640,
    parameter int unsigned V_PIXEL = 480,
    parameter int unsigned H_BLANK = 160,
    parameter int unsigned VS_CLK  = 1600,
    parameter int unsigned V_BACK  = 800,
    parameter int unsigned V_FRONT = 800
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       tx_en,
    input  logic       pattern_sel,
    output logic       dvp_vsync,
    output logic       dvp_href,
    output logic [7:0] dvp_data,
    output logic       busy,
    output logic       frame_done
);

    localparam int unsigned LINE_BYTES = 2 * H_PIXEL;
    localparam int unsigned CNT_MAX    = max_u(max_u(max_u(VS_CLK, V_BACK), max_u(V_FRONT, H_BLANK)),
                                               LINE_BYTES);
    localparam int unsigned CW         = $clog2(CNT_MAX + 1);
    localparam int unsigned LW         = $clog2(V_PIXEL + 1);

    localparam logic [CW-1:0] VS_LAST   = CW'(VS_CLK - 1);
    localparam logic [CW-1:0] VB_LAST   = CW'(V_BACK - 1);
    localparam logic [CW-1:0] LINE_LAST = CW'(LINE_BYTES - 1);
    localparam logic [CW-1:0] HB_LAST   = CW'(H_BLANK - 1);
    localparam logic [CW-1:0] VF_LAST   = CW'(V_FRONT - 1);
    localparam logic [CW-1:0] VF_PEN    = CW'((V_FRONT >= 2) ? V_FRONT - 2 : 0);

    dvp_state_e    state_q;
    logic [CW-1:0] cnt_q;   // clocks spent in the current state
    logic [CW-1:0] bx_q;    // index of the next byte to put on the line
    logic [LW-1:0] line_q;  // lines completed in this frame
    logic          pat_q;   // pattern chosen at VSYNC entry

    logic [15:0] gen_pixel;
    logic [15:0] pixel;
    logic [7:0]  byte_nxt;

    dvp_pattern_gen #(
        .H_PIXEL(H_PIXEL)
    ) u_gen (
        .x          (16'(bx_q >> 1)),
        .y          (16'(line_q)),
        .pattern_sel(pat_q),
        .pixel      (gen_pixel)
    );

`ifdef DVP_TX_FRAME_TAG_EN
    logic [15:0] tag_q;

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            tag_q <= '0;
        end else if (frame_done) begin
            tag_q <= tag_q + 16'd1;
        end
    end

    assign pixel = (((bx_q >> 1) == '0) && (line_q == '0)) ? tag_q : gen_pixel;
`else
    assign pixel = gen_pixel;
`endif

    assign byte_nxt = bx_q[0] ? pixel[7:0] : pixel[15:8];

    // Outputs are loaded on the same edge as the state they belong to, so
    // vsync/href/data always line up with state_q. bx_q points one byte ahead
    // of what is on dvp_data, which lets the byte be registered without a
    // separate next-state decode.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bx_q       <= '0;
            line_q     <= '0;
            pat_q      <= 1'b0;
            dvp_vsync  <= 1'b0;
            dvp_href   <= 1'b0;
            dvp_data   <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (tx_en) begin
                        state_q   <= VSYNC;
                        cnt_q     <= '0;
                        bx_q      <= '0;
                        line_q    <= '0;
                        pat_q     <= pattern_sel;
                        dvp_vsync <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                VSYNC: begin
                    if (cnt_q == VS_LAST) begin
                        state_q   <= VBACK;
                        cnt_q     <= '0;
                        dvp_vsync <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                VBACK: begin
                    if (cnt_q == VB_LAST) begin
                        state_q  <= ACTIVE;
                        cnt_q    <= '0;
                        dvp_href <= 1'b1;
                        dvp_data <= byte_nxt;
                        bx_q     <= bx_q + CW'(1);
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                ACTIVE: begin
                    if (cnt_q == LINE_LAST) begin
                        state_q  <= HBLANK;
                        cnt_q    <= '0;
                        dvp_href <= 1'b0;
                        dvp_data <= '0;
                        bx_q     <= '0;
                        line_q   <= line_q + LW'(1);
                    end else begin
                        cnt_q    <= cnt_q + CW'(1);
                        dvp_data <= byte_nxt;
                        bx_q     <= bx_q + CW'(1);
                    end
                end
                HBLANK: begin
                    if (cnt_q == HB_LAST) begin
                        cnt_q <= '0;
                        if (line_q < LW'(V_PIXEL)) begin
                            state_q  <= ACTIVE;
                            dvp_href <= 1'b1;
                            dvp_data <= byte_nxt;
                            bx_q     <= bx_q + CW'(1);
                        end else begin
                            state_q    <= VFRONT;
                            frame_done <= (V_FRONT == 1);
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                VFRONT: begin
                    if (cnt_q == VF_LAST) begin
                        cnt_q <= '0;
                        if (tx_en) begin
                            state_q   <= VSYNC;
                            bx_q      <= '0;
                            line_q    <= '0;
                            pat_q     <= pattern_sel;
                            dvp_vsync <= 1'b1;
                        end else begin
                            state_q <= IDLE;
                            busy    <= 1'b0;
                        end
                    end else begin
                        cnt_q      <= cnt_q + CW'(1);
                        frame_done <= (cnt_q == VF_PEN);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dvp_pattern_tx.sv
// tb_dvp_pattern_tx
//   Directed bench for dvp_pattern_tx with small frames (16/4/4/8/6/5) plus a
//   second instance with H_PIXEL=20 for the partial-bar case.
module tb_dvp_pattern_tx;

`ifdef DVP_TX_FRAME_TAG_EN
    localparam bit TAG = 1'b1;
`else
    localparam bit TAG = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n, tx_en, psel, tx_en20, psel20;
    logic       vs, hr, busy, fd;
    logic [7:0] data;
    logic       vs20, hr20, busy20, fd20;
    logic [7:0] data20;

    bit   use20 = 1'b0;
    logic s_vs, s_hr, s_busy, s_fd;
    logic [7:0] s_data;

    int n_assert = 0;
    int n_fail   = 0;

    int vs_len, back_len, nlines, bidx, zero_viol, busy_low;
    int href_len [8];
    int gap_len  [8];
    logic [7:0] cap [8][64];

    logic [15:0] BARS16 [16] = '{16'hFFFF, 16'hFFFF, 16'hFFE0, 16'hFFE0,
                                 16'h07FF, 16'h07FF, 16'h07E0, 16'h07E0,
                                 16'hF81F, 16'hF81F, 16'hF800, 16'hF800,
                                 16'h001F, 16'h001F, 16'h0000, 16'h0000};

    always #5 clk = ~clk;

    dvp_pattern_tx #(
        .H_PIXEL(16), .V_PIXEL(4), .H_BLANK(4), .VS_CLK(8), .V_BACK(6), .V_FRONT(5)
    ) dut (
        .sys_clk(clk), .sys_rst_n(rst_n), .tx_en(tx_en), .pattern_sel(psel),
        .dvp_vsync(vs), .dvp_href(hr), .dvp_data(data), .busy(busy), .frame_done(fd)
    );

    dvp_pattern_tx #(
        .H_PIXEL(20), .V_PIXEL(4), .H_BLANK(4), .VS_CLK(8), .V_BACK(6), .V_FRONT(5)
    ) dut20 (
        .sys_clk(clk), .sys_rst_n(rst_n), .tx_en(tx_en20), .pattern_sel(psel20),
        .dvp_vsync(vs20), .dvp_href(hr20), .dvp_data(data20), .busy(busy20), .frame_done(fd20)
    );

    assign s_vs   = use20 ? vs20   : vs;
    assign s_hr   = use20 ? hr20   : hr;
    assign s_data = use20 ? data20 : data;
    assign s_busy = use20 ? busy20 : busy;
    assign s_fd   = use20 ? fd20   : fd;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for vsync, then records one frame up to frame_done.
    // When line act_line starts, tx_en/pattern_sel are set to new_en/new_ps.
    task automatic capture_frame(input int act_line, input bit new_en, input bit new_ps,
                                 output bit ok);
        bit seen;
        bit prev_hr;
        int li;
        ok = 1'b0; seen = 1'b0; prev_hr = 1'b0;
        vs_len = 0; back_len = 0; nlines = 0; bidx = 0; zero_viol = 0; busy_low = 0;
        for (int i = 0; i < 8; i++) begin
            href_len[i] = 0;
            gap_len[i]  = 0;
            for (int j = 0; j < 64; j++) cap[i][j] = 8'h00;
        end
        for (int i = 0; i < 1000 && !seen; i++) begin
            @(negedge clk);
            if (s_vs) seen = 1'b1;
        end
        if (!seen) return;
        vs_len = 1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (!s_busy) busy_low++;
            if (!s_hr && s_data != 8'h00) zero_viol++;
            if (s_vs) begin
                vs_len++;
            end else if (s_hr) begin
                if (!prev_hr) begin
                    nlines++;
                    bidx = 0;
                    if (nlines == act_line + 1) begin
                        if (use20) begin tx_en20 = new_en; psel20 = new_ps; end
                        else       begin tx_en   = new_en; psel   = new_ps; end
                    end
                end
                li = (nlines > 8) ? 7 : nlines - 1;
                if (bidx < 64) cap[li][bidx] = s_data;
                bidx++;
                href_len[li]++;
            end else if (nlines == 0) begin
                back_len++;
            end else begin
                gap_len[(nlines > 8) ? 7 : nlines - 1]++;
            end
            prev_hr = s_hr;
            if (s_fd) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    initial begin
        bit ok;
        int err;
        int hit;
        logic [15:0] p;
        logic [7:0]  e;

        rst_n = 1'b0; tx_en = 1'b0; psel = 1'b0; tx_en20 = 1'b0; psel20 = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {vs, hr, data, busy, fd}, 32'h0);
        check("reset_outputs_h20", {vs20, hr20, data20, busy20, fd20}, 32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_no_enable", {vs, hr, busy}, 32'h0);

        // Frame A: bars, tx_en dropped during line 1.
        tx_en = 1'b1; psel = 1'b0;
        capture_frame(1, 1'b0, 1'b0, ok);
        check("A_frame_seen", ok, 1);
        check("A_vsync_len", vs_len, 8);
        check("A_back_porch", back_len, 6);
        check("A_lines", nlines, 4);
        err = 0;
        for (int y = 0; y < 4; y++) if (href_len[y] != 32) err++;
        check("A_href_len", err, 0);
        check("A_gap0", gap_len[0], 4);
        check("A_gap2", gap_len[2], 4);
        check("A_tail", gap_len[3], 9);
        check("A_bytes2_5", {cap[0][2], cap[0][3], cap[0][4], cap[0][5]}, 32'hFFFFFFE0);
        check("A_bytes6_9", {cap[0][6], cap[0][7], cap[0][8], cap[0][9]}, 32'hFFE007FF);
        check("A_pix00", {cap[0][0], cap[0][1]}, TAG ? 32'h0000 : 32'hFFFF);
        err = 0;
        for (int y = 0; y < 4; y++)
            for (int b = 0; b < 32; b++) begin
                if (y == 0 && b < 2) continue;
                p = BARS16[b / 2];
                e = (b % 2 == 1) ? p[7:0] : p[15:8];
                if (cap[y][b] !== e) err++;
            end
        check("A_bars_all", err, 0);
        check("A_idle_data_zero", zero_viol, 0);
        check("A_busy_in_frame", busy_low, 0);
        @(negedge clk);
        check("A_done_single_busy_low", {fd, busy}, 32'h0);
        hit = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (vs || busy || fd || hr) hit++;
        end
        check("A_stays_idle", hit, 0);

        // Frame B: ramp; pattern_sel flipped to bars during line 1.
        tx_en = 1'b1; psel = 1'b1;
        capture_frame(1, 1'b1, 1'b0, ok);
        check("B_frame_seen", ok, 1);
        check("B_lines", nlines, 4);
        check("B_line2_first", {cap[2][0], cap[2][1], cap[2][2], cap[2][3]}, 32'h00020003);
        check("B_line3_last", {cap[3][30], cap[3][31]}, 32'h0012);
        check("B_pix00", {cap[0][0], cap[0][1]}, TAG ? 32'h0001 : 32'h0000);
        err = 0;
        for (int y = 0; y < 4; y++)
            for (int b = 0; b < 32; b++) begin
                if (y == 0 && b < 2) continue;
                p = 16'(b / 2 + y);
                e = (b % 2 == 1) ? p[7:0] : p[15:8];
                if (cap[y][b] !== e) err++;
            end
        check("B_ramp_all", err, 0);

        // Frame C: back-to-back, new pattern (bars) now visible; tx_en dropped.
        capture_frame(1, 1'b0, 1'b0, ok);
        check("C_frame_seen", ok, 1);
        check("C_vsync_len", vs_len, 8);
        check("C_pix00", {cap[0][0], cap[0][1]}, TAG ? 32'h0002 : 32'hFFFF);
        check("C_bytes2_5", {cap[0][2], cap[0][3], cap[0][4], cap[0][5]}, 32'hFFFFFFE0);
        check("C_line3_last", {cap[3][30], cap[3][31]}, 32'h0000);
        repeat (2) @(negedge clk);
        check("C_back_idle", {vs, busy}, 32'h0);

        // Frame D: reset for one clock in the middle of a line, then restart.
        tx_en = 1'b1; psel = 1'b0;
        hit = 0;
        for (int i = 0; i < 200 && hit == 0; i++) begin
            @(negedge clk);
            if (hr) hit = 1;
        end
        check("D_reached_active", hit, 1);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("D_mid_reset_outputs", {vs, hr, data, busy, fd}, 32'h0);
        rst_n = 1'b1;
        capture_frame(1, 1'b0, 1'b0, ok);
        check("D_frame_seen", ok, 1);
        check("D_vsync_len", vs_len, 8);
        check("D_back_porch", back_len, 6);
        check("D_lines", nlines, 4);
        check("D_pix00", {cap[0][0], cap[0][1]}, TAG ? 32'h0000 : 32'hFFFF);
        err = 0;
        for (int b = 2; b < 32; b++) begin
            p = BARS16[b / 2];
            e = (b % 2 == 1) ? p[7:0] : p[15:8];
            if (cap[0][b] !== e) err++;
        end
        check("D_line0_bars", err, 0);
        repeat (3) @(negedge clk);

        // Frame E: H_PIXEL=20 instance, columns 16..19 past the last bar.
        use20 = 1'b1;
        tx_en20 = 1'b1; psel20 = 1'b0;
        capture_frame(1, 1'b0, 1'b0, ok);
        check("E_frame_seen", ok, 1);
        check("E_href_len", href_len[0], 40);
        check("E_bytes2_5", {cap[0][2], cap[0][3], cap[0][4], cap[0][5]}, 32'hFFFFFFE0);
        check("E_x12_13", {cap[0][24], cap[0][25], cap[0][26], cap[0][27]}, 32'h001F001F);
        check("E_x16_17", {cap[1][32], cap[1][33], cap[1][34], cap[1][35]}, 32'h0);
        check("E_x18_19", {cap[1][36], cap[1][37], cap[1][38], cap[1][39]}, 32'h0);
        check("E_idle_data_zero", zero_viol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/dvp_pattern_tx.md
DVP_PATTERN_TX -- requirements
Module: dvp_pattern_tx

Interface
REQ-001 The block SHALL have these parameters: H_PIXEL, default 640, active pixels per line.
REQ-002 The block SHALL have these parameters: V_PIXEL, default 480, active lines per frame.
REQ-003 The block SHALL have these parameters: H_BLANK, default 160, href-low clocks after each line.
REQ-004 The block SHALL have these parameters: VS_CLK, default 1600, vsync-high clocks per frame.
REQ-005 The block SHALL have these parameters: V_BACK, default 800, clocks from vsync fall to first href.
REQ-006 The block SHALL have these parameters: V_FRONT, default 800, clocks from last line blank to frame end.
REQ-007 Port sys_clk, input, 1: single clock; one DVP byte per clock.
REQ-008 Port sys_rst_n, input, 1: reset, synchronous and active-low.
REQ-009 Port tx_en, input, 1: run request, sampled only at frame boundaries.
REQ-010 Port pattern_sel, input, 1: 0 = colour bars, 1 = ramp; sampled at frame start.
REQ-011 Port dvp_vsync, output, 1: frame sync, active high.
REQ-012 Port dvp_href, output, 1: line valid, active high.
REQ-013 Port dvp_data, output, 8: pixel byte.
REQ-014 Port busy, output, 1: high from IDLE exit until return to IDLE.
REQ-015 Port frame_done, output, 1: one-clock pulse on last V_FRONT clock.

Function
REQ-016 The block SHALL implement FSM states IDLE, VSYNC, VBACK, ACTIVE, HBLANK, VFRONT.
REQ-017 IDLE->VSYNC when tx_en=1; VSYNC lasts VS_CLK clocks with dvp_vsync=1.
REQ-018 VSYNC->VBACK for V_BACK clocks, then ACTIVE.
REQ-019 ACTIVE lasts 2*H_PIXEL clocks with dvp_href=1, then HBLANK for H_BLANK clocks.
REQ-020 HBLANK->ACTIVE while line count < V_PIXEL, else ->VFRONT.
REQ-021 VFRONT lasts V_FRONT clocks; at its end the block SHALL go to VSYNC if tx_en=1, else IDLE.
REQ-022 Each pixel SHALL be RGB565 sent as high byte then low byte, byte 0 of a line being the high byte of pixel x=0.
REQ-023 Colour bars SHALL be 8 bars of width H_PIXEL/8 (integer), left to right FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000; pixels beyond 8*(H_PIXEL/8) SHALL use 0000.
REQ-024 Ramp pixel value SHALL be (x + y) truncated to 16 bits, x = column, y = line, both from 0.
REQ-025 dvp_data SHALL be 8'h00 whenever dvp_href=0.
REQ-026 dvp_vsync, dvp_href and dvp_data SHALL be registered and mutually aligned, with no combinational path from inputs.
REQ-027 Deassertion of tx_en mid-frame SHALL NOT truncate the frame; the frame completes and then the FSM goes to IDLE.
REQ-028 pattern_sel changes mid-frame SHALL take effect at the next VSYNC entry only.
REQ-029 Counters SHALL be sized for the parameter maxima and SHALL never wrap within a state.

Reset
REQ-030 sys_rst_n=0 at a sys_clk edge SHALL force IDLE, all counters to 0, and dvp_vsync, dvp_href, dvp_data, busy and frame_done to 0, including mid-frame.
REQ-031 After reset release, the first VSYNC SHALL start no earlier than the clock after tx_en is sampled 1.

Configuration
REQ-032 With DVP_TX_FRAME_TAG_EN defined, pixel (0,0) of each frame SHALL carry a 16-bit frame counter (reset 0, incremented at each frame_done, wrapping) instead of the pattern value.
REQ-033 Without DVP_TX_FRAME_TAG_EN, pixel (0,0) SHALL carry the pattern value and the counter SHALL not exist.

Structure
REQ-034 The state enum and the eight RGB565 bar constants SHALL live in a shared package dvp_tx_pkg.
REQ-035 Pixel value generation SHALL be one sub-module dvp_pattern_gen (inputs x, y, pattern_sel; output 16-bit pixel); FSM and counters SHALL stay in the top.

Verification
REQ-036 Params 16/4/4/8/6/5, tx_en=1 for one frame, bars: vsync high 8 clocks, href rises 6 clocks after vsync falls, 4 lines of 32 href clocks with 4-clock gaps, line bytes FF,FF,FF,FF,FF,E0,FF,E0,07,FF...
REQ-037 Ramp, same params: line 2 first bytes 00,02,00,03; line 3 last pixel 0x0012 (x=15, y=3).
REQ-038 tx_en dropped during line 1: frame completes, frame_done pulses once, busy falls, no second vsync.
REQ-039 sys_rst_n=0 for 1 clock mid-ACTIVE: next clock all outputs 0; restart with tx_en=1 gives a full fresh frame.
REQ-040 H_PIXEL=20 bars: x=16..19 output 0000; pattern_sel toggled mid-frame: change visible only in the next frame.
REQ-041 DVP_TX_FRAME_TAG_EN defined, 3 back-to-back frames: pixel (0,0) = 0000, 0001, 0002; undefined: FFFF each frame.
